// File: rtl/spawn_if.sv
// spawn_if: frame pulse, random value, lane requests and grant bundle for spawn_scheduler
interface spawn_if #(parameter int NUM_REQ = 4);
  logic startOfFrame;
  logic [3:0] random;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [3:0] grant_value;
  logic busy;
  modport master(output startOfFrame, random, req, input grant, grant_value, busy);
  modport slave(input startOfFrame, random, req, output grant, grant_value, busy);
endinterface

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: once-per-frame round-robin spawn arbiter; per-lane cooldown when SPAWN_COOLDOWN_EN is defined
module spawn_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W = 3
) (
  input logic clk,
  input logic reset,
  spawn_if.slave s
);
  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;
  state_t state, state_n;
  logic pending;
  logic [PTR_W-1:0] ptr, win, win_n;
  logic [NUM_REQ-1:0] elig, gnt;
  logic [3:0] gval, val_n;
  logic frame_go;
  assign frame_go = state == IDLE && (s.startOfFrame || pending);
`ifdef SPAWN_COOLDOWN_EN
  logic [3:0] cd [NUM_REQ];
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) elig[i] = s.req[i] && cd[i] == 4'd0;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (reset) cd[i] <= '0;
      else if (frame_go && cd[i] != 4'd0) cd[i] <= cd[i] - 4'd1;
      else if (state == GRANT && PTR_W'(i) == win) cd[i] <= gval;
`else
  assign elig = s.req;
`endif
  assign val_n = s.random == 4'd0 ? 4'd1 : s.random > 4'd12 ? 4'd12 : s.random;
  // later overwrites come from smaller offsets, so the lane nearest after ptr wins
  always_comb begin
    win_n = ptr;
    for (int k = NUM_REQ; k >= 1; k--)
      for (int i = 0; i < NUM_REQ; i++)
        if (elig[i] && i == (int'(ptr) + k) % NUM_REQ) win_n = PTR_W'(i);
  end
  always_comb begin
    state_n = state == IDLE ? (frame_go ? ARB : IDLE) :
              state == ARB ? (|elig ? GRANT : IDLE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pending <= 1'b0;
      ptr <= PTR_W'(NUM_REQ - 1);
      win <= '0;
      gnt <= '0;
      gval <= '0;
    end else begin
      state <= state_n;
      gnt <= '0;
      gval <= '0;
      pending <= state == IDLE ? 1'b0 : (pending || s.startOfFrame);
      if (state == ARB && |elig) begin
        win <= win_n;
        gnt <= NUM_REQ'(1) << win_n;
        gval <= val_n;
      end
      if (state == GRANT) ptr <= win;
    end
  end
  assign s.grant = gnt;
  assign s.grant_value = gval;
  assign s.busy = state != IDLE;
endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: table-driven frame vectors plus pending and mid-grant reset sequences
module tb_spawn_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  spawn_if #(.NUM_REQ(4)) bus();
  spawn_scheduler #(.NUM_REQ(4), .PTR_W(3)) dut(.clk(clk), .reset(reset), .s(bus.slave));
  int pass_cnt = 0;
  int total = 0;
  typedef struct {
    logic [3:0] req;
    logic [3:0] rnd;
    logic [3:0] g;
    logic [3:0] gv;
  } vec_t;
  vec_t v[$];
  task automatic add(input logic [3:0] r, input logic [3:0] rnd, input logic [3:0] g, input logic [3:0] gv);
    vec_t e;
    e.req = r;
    e.rnd = rnd;
    e.g = g;
    e.gv = gv;
    v.push_back(e);
  endtask
  task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
    total++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    tick;
  endtask
  task automatic frame(input string n, input logic [3:0] r, input logic [3:0] rnd, input logic [3:0] g, input logic [3:0] gv);
    bus.req = r;
    bus.random = rnd;
    bus.startOfFrame = 1'b1;
    tick;
    bus.startOfFrame = 1'b0;
    chk({n, "_busy_arb"}, 4'(bus.busy), 4'd1);
    chk({n, "_grant_arb"}, bus.grant, 4'd0);
    tick;
    chk({n, "_grant"}, bus.grant, g);
    if (g != 4'd0) chk({n, "_gval"}, bus.grant_value, gv);
    chk({n, "_busy_grant"}, 4'(bus.busy), 4'(g != 4'd0));
    tick;
    chk({n, "_grant_clr"}, bus.grant, 4'd0);
    chk({n, "_busy_idle"}, 4'(bus.busy), 4'd0);
  endtask
  initial begin
    bus.startOfFrame = 1'b0;
    bus.req = 4'd0;
    bus.random = 4'd0;
    tick;
    tick;
    chk("rst_grant", bus.grant, 4'd0);
    chk("rst_busy", 4'(bus.busy), 4'd0);
    reset = 1'b0;
    tick;
    add(4'h0, 4'd5, 4'h0, 4'd0);
    add(4'h0, 4'd7, 4'h0, 4'd0);
`ifdef SPAWN_COOLDOWN_EN
    add(4'hf, 4'd5, 4'h1, 4'd5);
    add(4'hf, 4'd5, 4'h2, 4'd5);
    add(4'hf, 4'd5, 4'h4, 4'd5);
    add(4'hf, 4'd5, 4'h8, 4'd5);
    add(4'hf, 4'd5, 4'h0, 4'd0);
    add(4'hf, 4'd5, 4'h1, 4'd5);
    add(4'hf, 4'd0, 4'h2, 4'd1);
    add(4'hf, 4'd15, 4'h4, 4'd12);
`else
    add(4'hf, 4'd5, 4'h1, 4'd5);
    add(4'hf, 4'd5, 4'h2, 4'd5);
    add(4'hf, 4'd5, 4'h4, 4'd5);
    add(4'hf, 4'd5, 4'h8, 4'd5);
    add(4'hf, 4'd5, 4'h1, 4'd5);
    add(4'hf, 4'd5, 4'h2, 4'd5);
    add(4'hf, 4'd0, 4'h4, 4'd1);
    add(4'hf, 4'd15, 4'h8, 4'd12);
    add(4'h5, 4'd9, 4'h1, 4'd9);
    add(4'h5, 4'd9, 4'h4, 4'd9);
    add(4'h5, 4'd9, 4'h1, 4'd9);
`endif
    foreach (v[i]) frame($sformatf("v%0d", i), v[i].req, v[i].rnd, v[i].g, v[i].gv);
    do_reset;
    bus.req = 4'hf;
    bus.random = 4'd3;
    bus.startOfFrame = 1'b1;
    tick;
    tick;
    chk("pend_grant1", bus.grant, 4'h1);
    chk("pend_gval1", bus.grant_value, 4'd3);
    tick;
    bus.startOfFrame = 1'b0;
    chk("pend_idle_busy", 4'(bus.busy), 4'd0);
    tick;
    chk("pend_arb_busy", 4'(bus.busy), 4'd1);
    tick;
    chk("pend_grant2", bus.grant, 4'h2);
    chk("pend_gval2", bus.grant_value, 4'd3);
    tick;
    chk("pend_done_busy", 4'(bus.busy), 4'd0);
    tick;
    chk("pend_drop_busy", 4'(bus.busy), 4'd0);
`ifdef SPAWN_COOLDOWN_EN
    frame("pend_cd1", 4'h1, 4'd3, 4'h0, 4'd0);
`else
    frame("pend_cd1", 4'h1, 4'd3, 4'h1, 4'd3);
`endif
    frame("pend_cd2", 4'h1, 4'd3, 4'h1, 4'd3);
    do_reset;
    frame("rg_load", 4'h4, 4'd7, 4'h4, 4'd7);
    bus.req = 4'h1;
    bus.random = 4'd7;
    bus.startOfFrame = 1'b1;
    tick;
    bus.startOfFrame = 1'b0;
    tick;
    chk("rg_grant", bus.grant, 4'h1);
    reset = 1'b1;
    tick;
    chk("rg_rst_grant", bus.grant, 4'd0);
    chk("rg_rst_busy", 4'(bus.busy), 4'd0);
    reset = 1'b0;
    tick;
    frame("rg_after", 4'h4, 4'd7, 4'h4, 4'd7);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
